// File: rtl/att_pkg.sv
// Shared definitions for the SROM attestation scheduler: state encoding,
// SROM address map and small helpers reusable by the access-control monitor.
package att_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        REQ,
        RUN,
        KILL
    } att_state_t;

    localparam logic [15:0] SROM_BASE          = 16'hA000;
    localparam logic [15:0] SROM_SIZE          = 16'h4000;
    localparam logic [15:0] SROM_ENTRY         = SROM_BASE;
    localparam logic [15:0] SROM_EXIT          = 16'(SROM_BASE + SROM_SIZE - 16'd2);
    localparam logic [15:0] SROM_RESET_HANDLER = 16'hFFFE;

    localparam logic [15:0] ATT_DEF_PERIOD  = 16'h1000;
    localparam logic [15:0] ATT_REQ_TIMEOUT = 16'h0400;
    localparam logic [15:0] ATT_RUN_TIMEOUT = 16'h8000;

    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] lo,
                                       input logic [15:0] hi);
        return (addr >= lo) && (addr <= hi);
    endfunction

    // True when one more tick would reach the limit; 17 bits so no limit value can wrap.
    function automatic logic limit_hit(input logic [15:0] cnt,
                                       input logic [15:0] limit);
        return ({1'b0, cnt} + 17'd1) >= {1'b0, limit};
    endfunction

endpackage

// File: rtl/srom_xfer_det.sv
// SROM boundary-crossing detector: remembers the previous pc and flags
// entries/exits into the SROM window and whether they used the legal address.
module srom_xfer_det
    import att_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE     = SROM_BASE,
    parameter logic [15:0] SMEM_SIZE     = SROM_SIZE,
    parameter logic [15:0] RESET_HANDLER = SROM_RESET_HANDLER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    output logic        in_srom,
    output logic        srom_entry,
    output logic        srom_exit,
    output logic        bad_entry,
    output logic        bad_exit
);

    localparam logic [15:0] SMEM_LAST = 16'(SMEM_BASE + SMEM_SIZE - 16'd2);

    logic [15:0] pc_prev;
    logic        prev_in;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_prev <= RESET_HANDLER;
        end else begin
            pc_prev <= pc;
        end
    end

    assign in_srom    = in_window(pc, SMEM_BASE, SMEM_LAST);
    assign prev_in    = in_window(pc_prev, SMEM_BASE, SMEM_LAST);
    assign srom_entry = !prev_in && in_srom;
    assign srom_exit  = prev_in && !in_srom;
    assign bad_entry  = srom_entry && (pc != SMEM_BASE);
    assign bad_exit   = srom_exit && (pc_prev != SMEM_LAST);

endmodule

// File: rtl/att_sched.sv
// Periodic SROM attestation scheduler: counts a period, requests attestation,
// and enforces atomic SROM entry/exit plus request and run deadlines.
module att_sched
    import att_pkg::*;
#(
    parameter logic [15:0] SMEM_BASE     = SROM_BASE,
    parameter logic [15:0] SMEM_SIZE     = SROM_SIZE,
    parameter logic [15:0] RESET_HANDLER = SROM_RESET_HANDLER,
    parameter logic [15:0] DEF_PERIOD    = ATT_DEF_PERIOD,
    parameter logic [15:0] REQ_TIMEOUT   = ATT_REQ_TIMEOUT,
    parameter logic [15:0] RUN_TIMEOUT   = ATT_RUN_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        cfg_wr,
    input  logic [15:0] cfg_data,
    output logic        att_irq,
    output logic        att_busy,
    output logic [7:0]  att_cnt,
    output logic        reset
);

    localparam att_state_t RST_STATE = (DEF_PERIOD == 16'd0) ? IDLE : COUNT;

    att_state_t  state_q, state_d, reload_state;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  att_cnt_d;
    logic        att_irq_d, att_busy_d, reset_d;

    logic in_srom, srom_entry, srom_exit, bad_entry, bad_exit;
    logic good_entry, good_exit, violation, cfg_ok;

    srom_xfer_det #(
        .SMEM_BASE    (SMEM_BASE),
        .SMEM_SIZE    (SMEM_SIZE),
        .RESET_HANDLER(RESET_HANDLER)
    ) u_det (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .in_srom   (in_srom),
        .srom_entry(srom_entry),
        .srom_exit (srom_exit),
        .bad_entry (bad_entry),
        .bad_exit  (bad_exit)
    );

    assign good_entry = srom_entry && !bad_entry;
    assign good_exit  = srom_exit && !bad_exit;
    assign violation  = bad_entry || bad_exit;
    // The write issued by the final SROM instruction lands on the exit edge, when pc is already outside.
    assign cfg_ok     = cfg_wr && (in_srom || (state_q == RUN && good_exit));

    // NOTE: every variable gets a default first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        att_cnt_d    = att_cnt;
        reload_state = COUNT;

        if (cfg_ok) begin
            period_d = cfg_data;
        end
        if (period_d == 16'd0) begin
            reload_state = IDLE;
        end

        case (state_q)
            IDLE: begin
                if (violation) begin
                    state_d = KILL;
                end else if (good_entry) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cfg_ok && cfg_data != 16'd0) begin
                    state_d = COUNT;
                    cnt_d   = cfg_data;
                end
            end
            COUNT: begin
                if (violation) begin
                    state_d = KILL;
                end else if (good_entry) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q <= 16'd1) begin
                    state_d = REQ;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            REQ: begin
                if (violation) begin
                    state_d = KILL;
                end else if (good_entry) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (limit_hit(cnt_q, REQ_TIMEOUT)) begin
                    state_d = KILL;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (violation || limit_hit(cnt_q, RUN_TIMEOUT)) begin
                    state_d = KILL;
                end else if (good_exit) begin
                    state_d   = reload_state;
                    cnt_d     = period_d;
                    att_cnt_d = att_cnt + 8'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            KILL: begin
                if (pc == RESET_HANDLER) begin
                    state_d = reload_state;
                    cnt_d   = period_d;
                end
            end
            default: state_d = KILL;
        endcase

        att_irq_d  = (state_d == REQ);
        att_busy_d = (state_d == RUN);
        reset_d    = (state_d == KILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RST_STATE;
            cnt_q    <= DEF_PERIOD;
            period_q <= DEF_PERIOD;
            att_cnt  <= '0;
            att_irq  <= 1'b0;
            att_busy <= 1'b0;
            reset    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            att_cnt  <= att_cnt_d;
            att_irq  <= att_irq_d;
            att_busy <= att_busy_d;
            reset    <= reset_d;
        end
    end

endmodule

// File: tb/tb_att_sched.sv
// Self-checking bench for att_sched: directed scenarios plus random pc/config
// traffic, checked every cycle against a deadline-based behavioural model.
module tb_att_sched;

    localparam logic [15:0] P_DEF = 16'h0010;
    localparam logic [15:0] T_REQ = 16'h0008;
    localparam logic [15:0] T_RUN = 16'h0030;

    localparam int M_IDLE  = 0;
    localparam int M_COUNT = 1;
    localparam int M_REQ   = 2;
    localparam int M_RUN   = 3;
    localparam int M_KILL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc = 16'h4000;
    logic        cfg_wr = 1'b0;
    logic [15:0] cfg_data = 16'h0000;
    logic        att_irq, att_busy, reset;
    logic [7:0]  att_cnt;

    att_sched #(
        .DEF_PERIOD (P_DEF),
        .REQ_TIMEOUT(T_REQ),
        .RUN_TIMEOUT(T_RUN)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pc      (pc),
        .cfg_wr  (cfg_wr),
        .cfg_data(cfg_data),
        .att_irq (att_irq),
        .att_busy(att_busy),
        .att_cnt (att_cnt),
        .reset   (reset)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [15:0] b16(input logic x);
        return {15'd0, x};
    endfunction

    // Behavioural model: absolute cycle deadlines instead of hardware counters.
    int          cyc;
    int          m_mode;
    int          t_fire;
    int          t_kill;
    logic [15:0] m_period;
    logic [15:0] m_pc_prev;
    logic [7:0]  m_acnt;

    function automatic bit tb_in_srom(input logic [15:0] a);
        return (a >= 16'hA000) && (a <= 16'hDFFE);
    endfunction

    task automatic model_reset();
        cyc       = 0;
        m_mode    = (P_DEF == 16'd0) ? M_IDLE : M_COUNT;
        t_fire    = int'(P_DEF);
        t_kill    = 0;
        m_period  = P_DEF;
        m_pc_prev = 16'hFFFE;
        m_acnt    = 8'd0;
    endtask

    task automatic model_step(input logic [15:0] p, input logic w, input logic [15:0] d);
        bit now_in, was_in, ent, ext, ent_ok, ext_ok, viol, wr_ok;
        cyc++;
        now_in = tb_in_srom(p);
        was_in = tb_in_srom(m_pc_prev);
        ent    = !was_in && now_in;
        ext    = was_in && !now_in;
        ent_ok = ent && (p == 16'hA000);
        ext_ok = ext && (m_pc_prev == 16'hDFFE);
        viol   = (ent && !ent_ok) || (ext && !ext_ok);
        wr_ok  = w && (now_in || (m_mode == M_RUN && ext_ok));
        if (wr_ok) m_period = d;
        if (m_mode != M_KILL && viol) begin
            m_mode = M_KILL;
        end else if (m_mode != M_RUN && m_mode != M_KILL && ent_ok) begin
            m_mode = M_RUN;
            t_kill = cyc + int'(T_RUN);
        end else begin
            case (m_mode)
                M_IDLE: if (wr_ok && d != 16'd0) begin
                    m_mode = M_COUNT;
                    t_fire = cyc + int'(d);
                end
                M_COUNT: if (cyc >= t_fire) begin
                    m_mode = M_REQ;
                    t_kill = cyc + int'(T_REQ);
                end
                M_REQ: if (cyc >= t_kill) m_mode = M_KILL;
                M_RUN: begin
                    if (cyc >= t_kill) begin
                        m_mode = M_KILL;
                    end else if (ext_ok) begin
                        m_acnt = m_acnt + 8'd1;
                        m_mode = (m_period == 16'd0) ? M_IDLE : M_COUNT;
                        t_fire = cyc + int'(m_period);
                    end
                end
                M_KILL: if (p == 16'hFFFE) begin
                    m_mode = (m_period == 16'd0) ? M_IDLE : M_COUNT;
                    t_fire = cyc + int'(m_period);
                end
                default: ;
            endcase
        end
        m_pc_prev = p;
    endtask

    task automatic check_outputs();
        check($sformatf("att_irq@%0d", cyc),  b16(att_irq),  b16(m_mode == M_REQ));
        check($sformatf("att_busy@%0d", cyc), b16(att_busy), b16(m_mode == M_RUN));
        check($sformatf("reset@%0d", cyc),    b16(reset),    b16(m_mode == M_KILL));
        check($sformatf("att_cnt@%0d", cyc),  {8'd0, att_cnt}, {8'd0, m_acnt});
    endtask

    task automatic tick(input logic [15:0] p, input logic w = 1'b0, input logic [15:0] d = 16'h0000);
        pc       = p;
        cfg_wr   = w;
        cfg_data = d;
        @(posedge clk);
        model_step(p, w, d);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n, input logic [15:0] p);
        for (int i = 0; i < n; i++) tick(p);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] app_addr();
        return 16'(2 * $urandom_range(0, 32'h4FFF));
    endfunction

    function automatic logic [15:0] srom_addr();
        return 16'(32'hA002 + 2 * $urandom_range(0, 32'h1FFD));
    endfunction

    task automatic rand_cycle();
        logic [15:0] p;
        logic        w;
        logic [15:0] d;
        int          r, pe;
        r = int'($urandom_range(99));
        if (m_mode == M_KILL && r < 25) begin
            p = 16'hFFFE;
        end else if (tb_in_srom(pc)) begin
            if (pc == 16'hDFFE && r < 70) p = app_addr();
            else if (r < 6)               p = 16'hDFFE;
            else if (r < 8)               p = app_addr();
            else                          p = srom_addr();
        end else begin
            pe = (m_mode == M_REQ) ? 25 : 4;
            if (r < pe)          p = 16'hA000;
            else if (r < pe + 2) p = srom_addr();
            else                 p = app_addr();
        end
        w = ($urandom_range(99) < 5);
        d = ($urandom_range(4) == 0) ? 16'h0000 : 16'($urandom_range(40, 2));
        tick(p, w, d);
    endtask

    initial begin
        #1;
        model_reset();
        check("rst_irq",   b16(att_irq),  16'd0);
        check("rst_busy",  b16(att_busy), 16'd0);
        check("rst_reset", b16(reset),    16'd0);
        check("rst_cnt",   {8'd0, att_cnt}, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Auto trigger, attestation run, reload
        ticks(15, 16'h4000);
        check("irq_before_period", b16(att_irq), 16'd0);
        tick(16'h4000);
        check("irq_at_period", b16(att_irq), 16'd1);
        tick(16'hA000);
        check("entry_clears_irq", b16(att_irq), 16'd0);
        check("busy_in_run", b16(att_busy), 16'd1);
        tick(16'hA002);
        tick(16'hA100);
        tick(16'hDFFE);
        tick(16'h4000);
        check("cnt_after_exit", {8'd0, att_cnt}, 16'd1);
        check("busy_after_exit", b16(att_busy), 16'd0);
        ticks(15, 16'h4000);
        check("irq_before_reload", b16(att_irq), 16'd0);
        tick(16'h4000);
        check("irq_after_reload", b16(att_irq), 16'd1);

        // Request timeout
        ticks(7, 16'h4000);
        check("no_kill_before_timeout", b16(reset), 16'd0);
        tick(16'h4000);
        check("req_timeout_kill", b16(reset), 16'd1);
        check("kill_clears_irq", b16(att_irq), 16'd0);
        tick(16'h4000);
        tick(16'hFFFE);
        check("kill_release", b16(reset), 16'd0);

        // Bad entry during COUNT
        ticks(3, 16'h4000);
        tick(16'hA010);
        check("bad_entry_kill", b16(reset), 16'd1);
        tick(16'hA020);
        check("kill_held_in_srom", b16(reset), 16'd1);
        tick(16'hFFFE);
        check("bad_entry_release", b16(reset), 16'd0);
        check("cnt_kept_after_kill", {8'd0, att_cnt}, 16'd1);

        // Entry on the request-timeout edge wins
        ticks(16, 16'h4000);
        ticks(7, 16'h4000);
        tick(16'hA000);
        check("entry_on_timeout_busy", b16(att_busy), 16'd1);
        check("entry_on_timeout_rst", b16(reset), 16'd0);

        // Bad exit
        tick(16'hA100);
        tick(16'h4400);
        check("bad_exit_kill", b16(reset), 16'd1);
        check("bad_exit_busy", b16(att_busy), 16'd0);
        tick(16'hFFFE);

        // Config guard: write outside SROM is dropped
        tick(16'h4000, 1'b1, 16'h0020);
        tick(16'hA000);
        tick(16'hDFFE);
        tick(16'h4000);
        ticks(15, 16'h4000);
        tick(16'h4000);
        check("period_unchanged", b16(att_irq), 16'd1);

        // Zero period written inside SROM parks the scheduler in IDLE
        tick(16'hA000);
        tick(16'hA200, 1'b1, 16'h0000);
        tick(16'hDFFE);
        tick(16'h4000);
        check("idle_after_zero_period", b16(att_busy), 16'd0);
        ticks(40, 16'h4000);
        check("idle_no_irq", b16(att_irq), 16'd0);

        // Write coinciding with the exit edge sets the reload value
        tick(16'hA000);
        tick(16'hDFFE);
        tick(16'h4000, 1'b1, 16'h0005);
        ticks(4, 16'h4000);
        check("new_cfg_not_yet", b16(att_irq), 16'd0);
        tick(16'h4000);
        check("reload_uses_new_cfg", b16(att_irq), 16'd1);

        // Asynchronous reset mid-RUN
        tick(16'hA000);
        tick(16'hA002);
        check("busy_before_async_rst", b16(att_busy), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", b16(att_busy), 16'd0);
        check("async_rst_irq",  b16(att_irq),  16'd0);
        check("async_rst_kill", b16(reset),    16'd0);
        check("async_rst_cnt",  {8'd0, att_cnt}, 16'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick(16'h4000);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rand_cycle();
            if ($urandom_range(999) == 0) async_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
